// File: rtl/serial_add_arbiter.sv
// serial_add_arbiter: round-robin arbiter feeding two requesters into a shared
// LSB-first bit-serial adder, returning sum/carry/id on a valid/ready port.
module serial_add_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_id,
  input  logic             res_ready
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, id_q, id_d, last_q, last_d;
  logic             grant0, grant1, sum_bit;
  // On a tie the requester that did not win last time is granted.
  assign grant0     = req0_valid && (!req1_valid || last_q);
  assign grant1     = req1_valid && (!req0_valid || !last_q);
  assign req0_ready = (state_q == IDLE) && grant0;
  assign req1_ready = (state_q == IDLE) && grant1;
  assign sum_bit    = a_q[0] ^ b_q[0] ^ carry_q;
  assign res_valid  = (state_q == DONE);
  assign res_sum    = sum_q;
  assign res_cout   = carry_q;
  assign res_id     = id_q;
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    last_d  = last_q;
    if (state_q == IDLE && (grant0 || grant1)) begin
      a_d     = grant1 ? req1_a : req0_a;
      b_d     = grant1 ? req1_b : req0_b;
      sum_d   = '0;
      carry_d = 1'b0;
      cnt_d   = '0;
      id_d    = grant1;
      last_d  = grant1;
      state_d = ADD;
    end else if (state_q == ADD) begin
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      sum_d   = (sum_q >> 1) | (WIDTH'(sum_bit) << (WIDTH - 1));
      carry_d = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
      cnt_d   = cnt_q + CW'(1);
      state_d = (cnt_q == CW'(WIDTH - 1)) ? DONE : ADD;
    end else if (state_q == DONE && res_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end
endmodule
